// File: rtl/lcd_wb_seq.sv
// Wishbone-programmed command/data buffer replayed to the LCD PHY stream, with
// FMARK-gated start, repeat count, abort and a readable status register.
module lcd_wb_seq #(
  parameter int BUF_AW = 8,
  parameter int PHY_DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        wb_addr,
  input  logic [31:0]       wb_wdata,
  output logic [31:0]       wb_rdata,
  input  logic              wb_we,
  input  logic              wb_cyc,
  output logic              wb_ack,
  output logic [PHY_DW-1:0] phy_data,
  output logic              phy_rs,
  output logic              phy_valid,
  input  logic              phy_ready,
  input  logic              phy_fmark_stb
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FM = 2'd1, RUN = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [PHY_DW:0]     buf_mem [0:(2**BUF_AW)-1];
  logic [BUF_AW-1:0]   last, cur_idx, f_idx;
  logic [7:0]          cur_rep, f_rep;
  logic                f_done, abort_pend, fm_sticky;
  logic                s1_valid, s1_rs;
  logic [PHY_DW-1:0]   s1_data;
  logic [31:0]         status;
  logic                wb_take, ctrl_wr, stat_rd, buf_wr, start, abort_now, abort_any;
  logic                xfer, out_free, final_beat, s2_load, fetch;
  logic                unused_wdata;

  assign unused_wdata = ^wb_wdata;

  assign wb_take    = wb_cyc && !wb_ack;
  assign ctrl_wr    = wb_take && wb_we && (wb_addr == 10'h000);
  assign stat_rd    = wb_take && !wb_we && (wb_addr == 10'h000);
  assign buf_wr     = wb_take && wb_we && wb_addr[9] && (state == IDLE);
  assign start      = ctrl_wr && (state == IDLE) && !wb_wdata[31];
  assign abort_now  = ctrl_wr && (state != IDLE) && wb_wdata[31];
  assign abort_any  = abort_now || abort_pend;
  assign xfer       = phy_valid && phy_ready;
  assign out_free   = !phy_valid || phy_ready;
  assign final_beat = (cur_idx == last) && (cur_rep == 8'd0);

  // Two-stage pipeline: s1 holds the prefetched entry, the output register is
  // stage 2. Entry 0 is prefetched in WAIT_FM so the beat can leave on the strobe.
  assign s2_load = s1_valid && out_free && !abort_any &&
                   ((state == RUN) || ((state == WAIT_FM) && phy_fmark_stb));
  assign fetch   = (state != IDLE) && !f_done && !abort_any && (!s1_valid || s2_load);

  always_comb begin
    status                = 32'd0;
    status[31]            = (state != IDLE);
    status[16 +: BUF_AW]  = cur_idx;
    status[15:8]          = cur_rep;
    status[0]             = fm_sticky;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = wb_wdata[1] ? WAIT_FM : RUN;
        else       state_nxt = IDLE;
      end
      WAIT_FM: begin
        if (abort_now)          state_nxt = IDLE;
        else if (phy_fmark_stb) state_nxt = RUN;
        else                    state_nxt = WAIT_FM;
      end
      RUN: begin
        if (abort_any && out_free)  state_nxt = IDLE;
        else if (xfer && final_beat) state_nxt = IDLE;
        else                         state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      abort_pend <= (state == RUN) && (state_nxt == RUN) && abort_any;
    end
  end

  // Strobe has priority over the clear-on-read of the sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack    <= 1'b0;
      wb_rdata  <= 32'd0;
      fm_sticky <= 1'b0;
    end else begin
      wb_ack    <= wb_take;
      wb_rdata  <= stat_rd ? status : 32'd0;
      if (phy_fmark_stb) fm_sticky <= 1'b1;
      else if (stat_rd)  fm_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= {BUF_AW{1'b0}};
      cur_idx <= {BUF_AW{1'b0}};
      f_idx   <= {BUF_AW{1'b0}};
      cur_rep <= 8'd0;
      f_rep   <= 8'd0;
      f_done  <= 1'b0;
    end else if (start) begin
      last    <= wb_wdata[16 +: BUF_AW];
      cur_idx <= {BUF_AW{1'b0}};
      f_idx   <= {BUF_AW{1'b0}};
      cur_rep <= wb_wdata[15:8];
      f_rep   <= wb_wdata[15:8];
      f_done  <= 1'b0;
    end else begin
      if (xfer) begin
        if (cur_idx != last) begin
          cur_idx <= cur_idx + BUF_AW'(1'b1);
        end else if (cur_rep != 8'd0) begin
          cur_idx <= {BUF_AW{1'b0}};
          cur_rep <= cur_rep - 8'd1;
        end
      end
      if (fetch) begin
        if (f_idx != last) begin
          f_idx <= f_idx + BUF_AW'(1'b1);
        end else if (f_rep != 8'd0) begin
          f_idx <= {BUF_AW{1'b0}};
          f_rep <= f_rep - 8'd1;
        end else begin
          f_done <= 1'b1;
        end
      end
    end
  end

  // Buffer storage and its registered read port; contents are not reset.
  always_ff @(posedge clk) begin
    if (buf_wr) buf_mem[wb_addr[BUF_AW-1:0]] <= {wb_wdata[16], wb_wdata[PHY_DW-1:0]};
    if (fetch)  {s1_rs, s1_data} <= buf_mem[f_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 s1_valid <= 1'b0;
    else if ((state_nxt == IDLE) || abort_any) s1_valid <= 1'b0;
    else if (fetch)                          s1_valid <= 1'b1;
    else if (s2_load)                        s1_valid <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phy_valid <= 1'b0;
      phy_data  <= {PHY_DW{1'b0}};
      phy_rs    <= 1'b0;
    end else if (s2_load) begin
      phy_valid <= 1'b1;
      phy_data  <= s1_data;
      phy_rs    <= s1_rs;
    end else if (xfer) begin
      phy_valid <= 1'b0;
    end
  end

endmodule

// File: doc/lcd_wb_seq.md
Name: lcd_wb_seq

Overview:
- Parametrised successor to the single-shot LCD Wishbone controller. It holds a command/data buffer written over Wishbone and replays a programmed range of it to the LCD PHY over a valid/ready stream.
- Adds three modes: start gated on the frame mark (FMARK) strobe, a programmable repeat count, and an abort bit.
- Adds a readable status register.
- Sits between the Wishbone bus and lcd_phy.

Parameters:
- BUF_AW, 8, log2 of buffer depth in entries; legal range 4..9.
- PHY_DW, 8, PHY data width; legal values 8 or 16.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wb_addr  in  10  word address; 0x000 = control/status, 0x200 + i = buffer entry i
- wb_wdata  in  32  write data
- wb_rdata  out  32  read data
- wb_we  in  1  write enable
- wb_cyc  in  1  cycle request
- wb_ack  out  1  cycle acknowledge
- phy_data  out  PHY_DW  byte/word to the PHY
- phy_rs  out  1  register-select bit to the PHY (0 = command, 1 = data)
- phy_valid  out  1  stream valid
- phy_ready  in  1  stream ready
- phy_fmark_stb  in  1  single-cycle FMARK strobe from the PHY

Behaviour:
- Reset state: state IDLE; wb_ack=0; wb_rdata=0; phy_valid=0; phy_data=0; phy_rs=0; all counters and sticky bits 0. Buffer contents are undefined after reset.
- Wishbone:
  - wb_ack pulses one cycle after wb_cyc is seen; it is never asserted in two consecutive cycles.
  - wb_rdata is valid with wb_ack and is 0 for any address other than 0x000.
- Buffer write (addr[9]=1), using index i = addr[BUF_AW-1:0]:
  - Stores {wdata[16], wdata[PHY_DW-1:0]} as {rs, data}.
  - Ignored while state != IDLE, but still acked.
- Control write to 0x000:
  - wdata[16+:BUF_AW] = LAST, the last entry index; the sequence is entries 0..LAST, i.e. LAST+1 beats.
  - wdata[15:8] = REP; the sequence is sent REP+1 times back to back.
  - wdata[1] = WAIT_FM.
  - wdata[31] = ABORT.
  - In IDLE with ABORT=0: latch the fields; go to WAIT_FM if WAIT_FM=1, otherwise RUN.
  - In any other state: only ABORT is honoured; all other fields are ignored.
- Status read from 0x000:
  - bit31 = busy (state != IDLE).
  - bit[16+:BUF_AW] = current index.
  - bits[15:8] = remaining repeats.
  - bit0 = fm_sticky.
  - The read clears fm_sticky. If a strobe lands on the same cycle as the read, the strobe wins and fm_sticky stays 1.
- fm_sticky is set by any phy_fmark_stb, in any state.
- State WAIT_FM: move to RUN on the cycle after the next phy_fmark_stb. A strobe that arrives on the same cycle as the control write does not count.
- State RUN:
  - Buffer read latency is 1 cycle. phy_valid rises no later than 2 cycles after RUN is entered.
  - Once asserted, phy_valid and phy_data/phy_rs hold until phy_ready=1.
  - On a transfer: if index < LAST, increment index. If index == LAST and repeats > 0, set index to 0 and decrement repeats. Otherwise go to IDLE.
  - The control block prefetches so that sustained phy_ready=1 gives one beat per cycle, including across the LAST-to-0 wrap.
- ABORT:
  - From WAIT_FM: go to IDLE next cycle.
  - From RUN: the beat currently on the bus (phy_valid=1) completes normally; no further beats are issued; then go to IDLE.
- LAST=0: exactly one beat per repeat.
- Index width is BUF_AW; it never exceeds LAST, so no wrap-around beyond LAST is possible.
- Asynchronous rst in the middle of a sequence: all outputs return to their reset values immediately. lcd_phy is reset from the same rst.

Test Plan:
- Write entries 0..11 = {0,0x01},{1,0xa5},...,{1,0x33}, then control 0x000b0000 with phy_ready tied 1 -> exactly 12 beats in order on consecutive cycles, rs per entry; busy=0 afterwards.
- Same buffer, control 0x00020200 (LAST=2, REP=2) -> 9 beats 0,1,2,0,1,2,0,1,2 with no bubble at the wraps.
- Control 0x00030002 (WAIT_FM); hold 50 cycles; then pulse phy_fmark_stb -> no phy_valid before the strobe; first beat 1 cycle after it; status bit0=1 on the first read, 0 on the second.
- Start a 12-beat run with phy_ready toggled every other cycle; write 0x80000000 after 3 beats -> beat 4 completes with data held stable while ready=0, then no more beats; busy=0.
- While busy, write 0x55 to 0x205 and 0x00000000 to 0x000 -> both acked, buffer entry 5 unchanged, running sequence unaffected.
- Assert rst mid-RUN -> phy_valid=0 and wb_ack=0 immediately; after release, status reads 0.
